// File: rtl/dlatch_writer.sv
// Write-side driver for a transparent D-latch bank: presents each accepted word on d
// with setup/strobe/hold windows and a one-entry pending buffer for back-to-back writes.
module dlatch_writer #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] d,
    output logic             en,
    output logic             busy,
    output logic             done
);

    localparam int unsigned MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int unsigned MAX_CYC = (STROBE_CYC > MAX_SH) ? STROBE_CYC : MAX_SH;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pend_full;
    logic [WIDTH-1:0] pend_data;
    logic             accept;
    logic             cnt_zero;
    logic             last_hold;

    assign in_ready  = !rst && !pend_full;
    assign accept    = in_valid && in_ready;
    assign cnt_zero  = (cnt == '0);
    assign last_hold = (state == HOLD) && cnt_zero;
    assign busy      = (state != IDLE);

    // Phase sequencer; d only loads on edges entering SETUP, where en is low and stays low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            d         <= '0;
            en        <= 1'b0;
            done      <= 1'b0;
            pend_full <= 1'b0;
            pend_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        d     <= in_data;
                        cnt   <= SETUP_LD;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_zero) begin
                        cnt   <= STROBE_LD;
                        en    <= 1'b1;
                        state <= STROBE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STROBE: begin
                    if (cnt_zero) begin
                        cnt   <= HOLD_LD;
                        en    <= 1'b0;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt_zero) begin
                        done <= 1'b1;
                        if (pend_full) begin
                            d         <= pend_data;
                            pend_full <= 1'b0;
                            cnt       <= SETUP_LD;
                            state     <= SETUP;
                        end else if (accept) begin
                            d     <= in_data;
                            cnt   <= SETUP_LD;
                            state <= SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Mid-write accepts park in the pending slot; the final HOLD edge bypasses it.
            if (accept && (state != IDLE) && !last_hold) begin
                pend_data <= in_data;
                pend_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dlatch_writer.sv
// Directed bench for dlatch_writer: default-parameter instance plus a
// SETUP=3/STROBE=1/HOLD=2, 16-bit instance.
module tb_dlatch_writer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  d;
    logic        en;
    logic        busy;
    logic        done;

    logic        p_valid;
    logic        p_ready;
    logic [15:0] p_data;
    logic [15:0] p_d;
    logic        p_en;
    logic        p_busy;
    logic        p_done;

    int vectors    = 0;
    int miscompares = 0;

    bit         bb_en  [13] = '{0,1,1,0,0,1,1,0,0,1,1,0,0};
    bit         bb_rdy [13] = '{1,0,0,0,1,0,0,0,1,1,1,1,1};
    bit         bb_done[13] = '{0,0,0,0,1,0,0,0,1,0,0,0,1};
    bit         bb_busy[13] = '{1,1,1,1,1,1,1,1,1,1,1,1,0};
    logic [7:0] bb_d   [13] = '{8'h11,8'h11,8'h11,8'h11,8'h22,8'h22,8'h22,8'h22,
                                8'h33,8'h33,8'h33,8'h33,8'h33};
    logic [7:0] words  [3]  = '{8'h11, 8'h22, 8'h33};

    dlatch_writer u_dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .d        (d),
        .en       (en),
        .busy     (busy),
        .done     (done)
    );

    dlatch_writer #(
        .WIDTH      (16),
        .SETUP_CYC  (3),
        .STROBE_CYC (1),
        .HOLD_CYC   (2)
    ) u_par (
        .clk      (clk),
        .rst      (rst),
        .in_valid (p_valid),
        .in_ready (p_ready),
        .in_data  (p_data),
        .d        (p_d),
        .en       (p_en),
        .busy     (p_busy),
        .done     (p_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word from IDLE with default timing; caller is just before the accept edge.
    task automatic run_single(input logic [7:0] w);
        in_valid = 1'b1;
        in_data  = w;
        tick();
        in_valid = 1'b0;
        chk("single_c0_d", 32'(d), 32'(w));
        chk("single_c0_en", 32'(en), 32'(0));
        chk("single_c0_busy", 32'(busy), 32'(1));
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk($sformatf("single_c%0d_en", c), 32'(en), 32'((c == 1) || (c == 2)));
            chk($sformatf("single_c%0d_done", c), 32'(done), 32'(c == 4));
            chk($sformatf("single_c%0d_busy", c), 32'(busy), 32'(c < 4));
            chk($sformatf("single_c%0d_d", c), 32'(d), 32'(w));
        end
    endtask

    initial begin
        logic acc;
        int   idx;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        p_valid  = 1'b0;
        p_data   = '0;
        #1;
        chk("rst_ready", 32'(in_ready), 32'(0));
        tick();
        tick();
        chk("rst_d", 32'(d), 32'(0));
        chk("rst_en", 32'(en), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_ready_held", 32'(in_ready), 32'(0));
        #3;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'(1));

        run_single(8'hA5);

        // Back-to-back with a producer holding in_valid; 33 stalls while the slot is full.
        idx      = 0;
        in_valid = 1'b1;
        in_data  = words[0];
        for (int c = 0; c <= 12; c++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
            in_valid = (idx < 3);
            in_data  = (idx < 3) ? words[idx] : 8'h00;
            chk($sformatf("b2b_c%0d_en", c), 32'(en), 32'(bb_en[c]));
            chk($sformatf("b2b_c%0d_d", c), 32'(d), 32'(bb_d[c]));
            chk($sformatf("b2b_c%0d_ready", c), 32'(in_ready), 32'(bb_rdy[c]));
            chk($sformatf("b2b_c%0d_done", c), 32'(done), 32'(bb_done[c]));
            chk($sformatf("b2b_c%0d_busy", c), 32'(busy), 32'(bb_busy[c]));
        end
        tick();
        chk("b2b_idle_done", 32'(done), 32'(0));

        // Bypass on the final HOLD edge.
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("byp_c3_d", 32'(d), 32'(8'h3C));
        chk("byp_c3_en", 32'(en), 32'(0));
        chk("byp_c3_ready", 32'(in_ready), 32'(1));
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid = 1'b0;
        chk("byp_c4_d", 32'(d), 32'(8'h5A));
        chk("byp_c4_en", 32'(en), 32'(0));
        chk("byp_c4_done", 32'(done), 32'(1));
        chk("byp_c4_busy", 32'(busy), 32'(1));
        tick();
        chk("byp_c5_en", 32'(en), 32'(1));
        tick();
        chk("byp_c6_en", 32'(en), 32'(1));
        tick();
        chk("byp_c7_en", 32'(en), 32'(0));
        tick();
        chk("byp_c8_done", 32'(done), 32'(1));
        chk("byp_c8_busy", 32'(busy), 32'(0));
        chk("byp_c8_d", 32'(d), 32'(8'h5A));

        // Reset mid-STROBE with a word pending.
        tick();
        in_valid = 1'b1;
        in_data  = 8'h77;
        tick();
        in_data  = 8'h88;
        tick();
        in_valid = 1'b0;
        chk("rmid_c1_en", 32'(en), 32'(1));
        chk("rmid_c1_ready", 32'(in_ready), 32'(0));
        tick();
        chk("rmid_c2_en", 32'(en), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rmid_en", 32'(en), 32'(0));
        chk("rmid_d", 32'(d), 32'(0));
        chk("rmid_busy", 32'(busy), 32'(0));
        chk("rmid_ready", 32'(in_ready), 32'(0));
        chk("rmid_done", 32'(done), 32'(0));
        #1;
        rst = 1'b0;
        #1;
        chk("rmid_ready_after", 32'(in_ready), 32'(1));
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("rmid_quiet%0d_done", c), 32'(done), 32'(0));
            chk($sformatf("rmid_quiet%0d_busy", c), 32'(busy), 32'(0));
            chk($sformatf("rmid_quiet%0d_en", c), 32'(en), 32'(0));
        end
        run_single(8'h99);

        // Wide instance: en one cycle at accept+3, done at accept+6.
        p_valid = 1'b1;
        p_data  = 16'hBEEF;
        tick();
        p_valid = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) tick();
            chk($sformatf("par_c%0d_en", c), 32'(p_en), 32'(c == 3));
            chk($sformatf("par_c%0d_done", c), 32'(p_done), 32'(c == 6));
            chk($sformatf("par_c%0d_busy", c), 32'(p_busy), 32'(c < 6));
            chk($sformatf("par_c%0d_d", c), 32'(p_d), 32'(16'hBEEF));
        end
        chk("par_ready", 32'(p_ready), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
